// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - shared op/state types and signedness decode for the multiply issue controller
package mul_ctrl_pkg;

  localparam int MUL_XLEN  = 32;
  localparam int MUL_TAG_W = 5;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } mul_state_e;

  // Returns {op1_signed, op2_signed}.
  function automatic logic [1:0] op_sign(input mul_op_e op);
    case (op)
      MUL_OP_MULH:   return 2'b11;
      MUL_OP_MULHSU: return 2'b10;
      default:       return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/booth4_multiplier_nbit.sv
// rtl/booth4_multiplier_nbit.sv - iterative radix-4 Booth multiplier, MUL_SIZE/2 compute cycles
module booth4_multiplier_nbit #(
  parameter int MUL_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MUL_SIZE-1:0]   mul_op1,
  input  logic [MUL_SIZE-1:0]   mul_op2,
  input  logic                  mul_op1_signed,
  input  logic                  mul_op2_signed,
  input  logic                  mul_valid,
  output logic                  mul_ready,
  output logic [2*MUL_SIZE-1:0] mul_res,
  output logic                  mul_res_valid,
  input  logic                  mul_res_ready
);

  localparam int STEPS = MUL_SIZE / 2;
  localparam int CW    = $clog2(STEPS);

  logic                  busy;
  logic                  done;
  logic [CW-1:0]         cnt;
  logic [2*MUL_SIZE-1:0] acc;
  logic [2*MUL_SIZE-1:0] a_sh;
  logic [MUL_SIZE:0]     b_sh;
  logic [2*MUL_SIZE-1:0] a_ext;
  logic [2*MUL_SIZE-1:0] pp;

  assign a_ext         = {{MUL_SIZE{mul_op1_signed & mul_op1[MUL_SIZE-1]}}, mul_op1};
  assign mul_ready     = !busy && !done;
  assign mul_res_valid = done;
  assign mul_res       = acc;

  always_comb begin
    pp = '0;
    case (b_sh[2:0])
      3'b001, 3'b010: pp = a_sh;
      3'b011:         pp = a_sh << 1;
      3'b100:         pp = -(a_sh << 1);
      3'b101, 3'b110: pp = -a_sh;
      default:        pp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (mul_valid && mul_ready) begin
      busy <= 1'b1;
      cnt  <= '0;
      a_sh <= a_ext;
      b_sh <= {mul_op2, 1'b0};
      // Booth treats op2 as signed; an unsigned op2 with its top bit set needs op1 * 2^MUL_SIZE added back.
      acc  <= (!mul_op2_signed && mul_op2[MUL_SIZE-1]) ? (a_ext << MUL_SIZE) : '0;
    end else if (busy) begin
      acc  <= acc + pp;
      a_sh <= a_sh << 2;
      b_sh <= b_sh >> 2;
      cnt  <= cnt + 1'b1;
      if (cnt == CW'(STEPS - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else if (done && mul_res_ready) begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_result_cache.sv
// rtl/mul_result_cache.sv - one-entry product cache with hit compare, fill, flush and no-fill flag
module mul_result_cache #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inflight,
  input  logic              release_nofill,
  input  logic [XLEN-1:0]   lookup_rs1,
  input  logic [XLEN-1:0]   lookup_rs2,
  input  logic [1:0]        lookup_sign,
  input  logic              lookup_is_mul,
  output logic              hit,
  input  logic              fill,
  input  logic [XLEN-1:0]   fill_rs1,
  input  logic [XLEN-1:0]   fill_rs2,
  input  logic [1:0]        fill_sign,
  input  logic [2*XLEN-1:0] fill_prod,
  output logic [2*XLEN-1:0] c_prod
);

  logic            cache_valid;
  logic            no_fill;
  logic [XLEN-1:0] c_rs1;
  logic [XLEN-1:0] c_rs2;
  logic [1:0]      c_sign;

  // The low half of the product does not depend on signedness, so MUL matches any cached pair.
  assign hit = cache_valid && !flush && (lookup_rs1 == c_rs1) && (lookup_rs2 == c_rs2) &&
               (lookup_is_mul || (lookup_sign == c_sign));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      no_fill     <= 1'b0;
      c_rs1       <= '0;
      c_rs2       <= '0;
      c_sign      <= 2'b00;
      c_prod      <= '0;
    end else begin
      if (flush) begin
        cache_valid <= 1'b0;
      end else if (fill && !no_fill) begin
        cache_valid <= 1'b1;
      end

      if (flush && inflight) begin
        no_fill <= 1'b1;
      end else if (release_nofill) begin
        no_fill <= 1'b0;
      end

      // The product is always kept so the in-flight request can be answered even when not cached.
      if (fill) begin
        c_rs1  <= fill_rs1;
        c_rs2  <= fill_rs2;
        c_sign <= fill_sign;
        c_prod <= fill_prod;
      end
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - M-extension multiply issue/writeback FSM with one-entry product cache
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int XLEN  = MUL_XLEN,
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [1:0]        in_op,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_flush,
  output logic [XLEN-1:0]   mul_op1,
  output logic [XLEN-1:0]   mul_op2,
  output logic              mul_op1_signed,
  output logic              mul_op2_signed,
  output logic              mul_valid,
  input  logic              mul_ready,
  input  logic [2*XLEN-1:0] mul_res,
  input  logic              mul_res_valid,
  output logic              mul_res_ready,
  output logic [XLEN-1:0]   out_rd,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_valid,
  input  logic              in_ready
);

  mul_state_e        state_q, state_d;
  mul_op_e           req_op, r_op;
  logic [1:0]        req_sign, r_sign;
  logic [XLEN-1:0]   r_rs1, r_rs2;
  logic              accept, hit, fill;
  logic [2*XLEN-1:0] c_prod;

  assign req_op   = mul_op_e'(in_op);
  assign req_sign = op_sign(req_op);
  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign fill     = (state_q == ST_WAIT) && mul_res_valid;

  mul_result_cache #(.XLEN(XLEN)) u_cache (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (in_flush),
    .inflight       ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
    .release_nofill ((state_q == ST_RESP) && in_ready),
    .lookup_rs1     (in_rs1),
    .lookup_rs2     (in_rs2),
    .lookup_sign    (req_sign),
    .lookup_is_mul  (req_op == MUL_OP_MUL),
    .hit            (hit),
    .fill           (fill),
    .fill_rs1       (r_rs1),
    .fill_rs2       (r_rs2),
    .fill_sign      (r_sign),
    .fill_prod      (mul_res),
    .c_prod         (c_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_op    <= MUL_OP_MUL;
      r_sign  <= 2'b00;
      r_rs1   <= '0;
      r_rs2   <= '0;
      out_tag <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        r_op    <= req_op;
        r_sign  <= req_sign;
        r_rs1   <= in_rs1;
        r_rs2   <= in_rs2;
        out_tag <= in_tag;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    out_ready     = 1'b0;
    mul_valid     = 1'b0;
    mul_res_ready = 1'b0;
    out_valid     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_ready = 1'b1;
        if (in_valid) state_d = hit ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        mul_valid = 1'b1;
        if (mul_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mul_res_ready = 1'b1;
        if (mul_res_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (in_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mul_op1        = r_rs1;
  assign mul_op2        = r_rs2;
  assign mul_op1_signed = r_sign[1];
  assign mul_op2_signed = r_sign[0];
  assign out_rd         = (r_op == MUL_OP_MUL) ? c_prod[XLEN-1:0] : c_prod[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - directed self-checking bench for mul_issue_ctrl with the Booth multiplier
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, in_flush, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_tag;
  logic [31:0] mul_op1, mul_op2;
  logic        mul_op1_signed, mul_op2_signed, mul_valid, mul_ready;
  logic [63:0] mul_res;
  logic        mul_res_valid, mul_res_ready;
  logic [31:0] out_rd;
  logic [4:0]  out_tag;
  logic        out_valid;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int lat;
  bit saw_mv;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .in_flush(in_flush),
    .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_op1_signed(mul_op1_signed),
    .mul_op2_signed(mul_op2_signed), .mul_valid(mul_valid), .mul_ready(mul_ready),
    .mul_res(mul_res), .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready),
    .out_rd(out_rd), .out_tag(out_tag), .out_valid(out_valid), .in_ready(in_ready)
  );

  booth4_multiplier_nbit #(.MUL_SIZE(32)) u_mul (
    .clk(clk), .rst_n(rst_n), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_op1_signed(mul_op1_signed), .mul_op2_signed(mul_op2_signed),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_res(mul_res),
    .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Accepts one request and returns at the first negedge with out_valid (or after the cycle budget).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int flush_at);
    @(negedge clk);
    check("ready_before_accept", out_ready, 1);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    saw_mv = 1'b0;
    while (!out_valid && lat < 64) begin
      if (mul_valid) saw_mv = 1'b1;
      in_flush = (lat == flush_at);
      @(negedge clk);
      lat++;
    end
    in_flush = 1'b0;
  endtask

  task automatic finish_resp();
    @(posedge clk);
    @(negedge clk);
    check("ready_after_handshake", out_ready, 1);
    check("valid_after_handshake", out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_ready"}, out_ready, 1);
    check({tag, "_mul_valid"}, mul_valid, 0);
    check({tag, "_mul_res_ready"}, mul_res_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_rd"}, out_rd, 0);
    check({tag, "_out_tag"}, out_tag, 0);
    check({tag, "_mul_ops"}, {mul_op1, mul_op2}, 0);
    check({tag, "_mul_signed"}, {mul_op1_signed, mul_op2_signed}, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_rs1 = '0; in_rs2 = '0;
    in_tag = '0; in_flush = 1'b0; in_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // MULHU all-ones: unsigned product 0xFFFFFFFE_00000001
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    check("mulhu_rd", out_rd, 32'hFFFF_FFFE);
    check("mulhu_tag", out_tag, 5'd3);
    check("mulhu_latency", lat, 19);
    finish_resp();

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    check("hit_rd", out_rd, 32'h0000_0001);
    check("hit_tag", out_tag, 5'd4);
    check("hit_latency", lat, 1);
    check("hit_no_mul_valid", saw_mv, 0);
    finish_resp();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0);
    check("mulh_rd", out_rd, 32'h0000_0000);
    check("mulh_latency", lat, 19);
    finish_resp();

    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
    check("mulhsu_rd", out_rd, 32'hFFFF_FFFF);
    check("mulhsu_latency", lat, 19);
    finish_resp();

    in_ready = 1'b0;
    issue(2'b00, 32'd7, 32'd6, 5'd7, 0);
    check("stall_latency", lat, 19);
    for (int i = 0; i < 5; i++) begin
      check("stall_rd", out_rd, 32'h0000_002A);
      check("stall_tag", out_tag, 5'd7);
      check("stall_valid", out_valid, 1);
      check("stall_out_ready", out_ready, 0);
      @(negedge clk);
    end
    in_ready = 1'b1;
    finish_resp();

    issue(2'b11, 32'd2, 32'd3, 5'd8, 10);
    check("flush_mulhu_rd", out_rd, 32'h0000_0000);
    check("flush_mulhu_latency", lat, 19);
    finish_resp();
    issue(2'b00, 32'd2, 32'd3, 5'd8, 0);
    check("after_flush_rd", out_rd, 32'h0000_0006);
    check("after_flush_latency", lat, 19);
    check("after_flush_mul_valid", saw_mv, 1);
    finish_resp();

    // Reset while the multiplier is computing.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'd12;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("wait_res_ready", mul_res_ready, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'd5, 32'd5, 5'd9, 0);
    check("post_reset_rd", out_rd, 32'h0000_0019);
    check("post_reset_tag", out_tag, 5'd9);
    check("post_reset_latency", lat, 19);
    finish_resp();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
